register_write_arbiter: RTL and testbench

- Shares one `register` instance (WIDTH bits, single update/new_value write port) between N requesters using round-robin arbitration.
- Sequences each write as a grant, then an update pulse, then a read-back check of curr_value, then an ack to the winner.
- Optional lock lets one owner issue back-to-back writes, bounded by LOCK_MAX for fairness.
- Sits directly in front of the register; the register's update/new_value/curr_value connect straight to this block.

---
 rtl/register_write_arbiter_pkg.sv | 25 ++
 rtl/register_write_arbiter_if.sv | 27 ++
 rtl/register_write_arbiter_rr_pick.sv | 32 +++
 rtl/register_write_arbiter.sv | 113 +++++++++++
 tb/tb_register_write_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/register_write_arbiter_pkg.sv
// Shared types and helpers for the register write arbiter.
// Holds the FSM state type and the one-hot grant helper.
package register_arb_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CHECK = 2'd2
    } state_e;

    function automatic logic [15:0] onehot(
        input int idx,
        input int n
    );
        logic [15:0] r;
        r = '0;
        if (idx >= 0 && idx < n && idx < 16) begin
            r[idx] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/register_write_arbiter_if.sv
// Requester and register-side signals of the write arbiter.
// slave = arbiter side, master = requesters plus the register.
interface register_write_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 4
);
    logic [N-1:0]       req;
    logic [N-1:0]       lock;
    logic [N*WIDTH-1:0] wdata;
    logic [N-1:0]       gnt;
    logic [N-1:0]       ack;
    logic               err;
    logic               busy;
    logic               update;
    logic [WIDTH-1:0]   new_value;
    logic [WIDTH-1:0]   curr_value;

    modport slave (
        input  req, lock, wdata, curr_value,
        output gnt, ack, err, busy, update, new_value
    );

    modport master (
        output req, lock, wdata, curr_value,
        input  gnt, ack, err, busy, update, new_value
    );
endinterface

// File: rtl/register_write_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches upward from ptr+1 using a double-width masked vector.
module register_rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] idx
);
    logic [N-1:0]   mask;
    logic [2*N-1:0] dbl;
    logic           found;

    // Lower copy holds only bits above ptr; upper copy wraps around.
    always_comb begin
        valid = |req;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i > int'(ptr));
        end
        dbl = {req, req & mask};
        for (int i = 0; i < 2 * N; i++) begin
            if (!found && dbl[i]) begin
                found = 1'b1;
                idx   = PW'(i % N);
            end
        end
    end
endmodule

// File: rtl/register_write_arbiter.sv
// Round-robin write arbiter in front of a single register.
// Each write: grant, update pulse, read-back check, ack.
module register_write_arbiter
    import register_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int WIDTH    = 4,
    parameter int LOCK_MAX = 4
) (
    input logic clk,
    input logic rst,
    register_write_arbiter_if.slave bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(LOCK_MAX + 1);

    state_e           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    widx_q, widx_d;
    logic [CW-1:0]    lcnt_q, lcnt_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic             update_q, update_d;
    logic [WIDTH-1:0] nv_q, nv_d;

    logic             pick_valid;
    logic [PW-1:0]    pick_idx;
    logic [15:0]      oh;
    logic             cont;

    register_rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next-state, datapath latch and lock counter.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        widx_d   = widx_q;
        lcnt_d   = lcnt_q;
        gnt_d    = gnt_q;
        update_d = 1'b0;
        nv_d     = nv_q;
        oh       = onehot(int'(pick_idx), N);
        cont     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    widx_d   = pick_idx;
                    nv_d     = bus.wdata[pick_idx*WIDTH +: WIDTH];
                    gnt_d    = oh[N-1:0];
                    update_d = 1'b1;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                state_d = CHECK;
            end
            CHECK: begin
                ptr_d = widx_q;
                cont  = bus.lock[widx_q] && bus.req[widx_q]
                     && (int'(lcnt_q) < LOCK_MAX - 1);
                if (cont) begin
                    lcnt_d   = lcnt_q + 1'b1;
                    nv_d     = bus.wdata[widx_q*WIDTH +: WIDTH];
                    update_d = 1'b1;
                    state_d  = WRITE;
                end else begin
                    lcnt_d  = '0;
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; requester 0 gets first priority after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= PW'(N - 1);
            widx_q   <= '0;
            lcnt_q   <= '0;
            gnt_q    <= '0;
            update_q <= 1'b0;
            nv_q     <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            widx_q   <= widx_d;
            lcnt_q   <= lcnt_d;
            gnt_q    <= gnt_d;
            update_q <= update_d;
            nv_q     <= nv_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.update    = update_q;
    assign bus.new_value = nv_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.ack       = (state_q == CHECK) ? gnt_q : '0;
    assign bus.err       = (state_q == CHECK)
                        && (bus.curr_value != nv_q);
endmodule

// File: tb/tb_register_write_arbiter.sv
// Testbench for register_write_arbiter with a register model.
// Table vectors, directed corner sequences and random traffic.
module tb_register_write_arbiter;
    localparam int N  = 4;
    localparam int W  = 4;
    localparam int LM = 3;

    logic clk;
    logic rst;
    logic [W-1:0] reg_q;
    logic force_en;
    logic [W-1:0] force_val;

    int checks;
    int failures;

    int m_phase;
    int m_owner;
    int m_last;
    int m_run;
    logic [W-1:0] m_nv;

    register_write_arbiter_if #(.N(N), .WIDTH(W)) bus ();

    register_write_arbiter #(
        .N        (N),
        .WIDTH    (W),
        .LOCK_MAX (LM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) reg_q <= '0;
        else if (bus.update) reg_q <= bus.new_value;
    end

    assign bus.curr_value = force_en ? force_val : reg_q;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [15:0] wdata;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic        upd;
        logic [3:0]  nv;
        logic        busy;
        logic        err;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(
        input string nm,
        input logic [31:0] act,
        input logic [31:0] want
    );
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_owner = 0;
        m_last  = N - 1;
        m_run   = 0;
        m_nv    = '0;
    endtask

    function automatic int pick(input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_adv();
        if (rst) begin
            model_reset();
        end else if (m_phase == 0) begin
            if (bus.req != 0) begin
                m_owner = pick(bus.req);
                m_nv    = bus.wdata[m_owner*W +: W];
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else begin
            m_last = m_owner;
            if (bus.lock[m_owner] && bus.req[m_owner]
                && m_run + 1 < LM) begin
                m_run++;
                m_nv    = bus.wdata[m_owner*W +: W];
                m_phase = 1;
            end else begin
                m_run   = 0;
                m_phase = 0;
            end
        end
    endtask

    task automatic check_model();
        logic [3:0] eg;
        logic [3:0] ea;
        logic       ee;
        eg = (m_phase != 0) ? 4'(1 << m_owner) : 4'b0;
        ea = (m_phase == 2) ? 4'(1 << m_owner) : 4'b0;
        ee = (m_phase == 2) && (bus.curr_value != m_nv);
        chk("m_gnt", 32'(bus.gnt), 32'(eg));
        chk("m_ack", 32'(bus.ack), 32'(ea));
        chk("m_err", 32'(bus.err), 32'(ee));
        chk("m_busy", 32'(bus.busy), 32'(m_phase != 0));
        chk("m_update", 32'(bus.update), 32'(m_phase == 1));
        chk("m_new_value", 32'(bus.new_value), 32'(m_nv));
    endtask

    task automatic step();
        @(posedge clk);
        model_adv();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bus.req   = '0;
        bus.lock  = '0;
        bus.wdata = '0;
        force_en  = 1'b0;
        force_val = '0;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_update", 32'(bus.update), 0);
        chk("rst_nv", 32'(bus.new_value), 0);
        chk("rst_ack", 32'(bus.ack), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int idx_of(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    int got_c[$];
    int got_i[$];
    int rr_c[5] = '{2, 5, 8, 11, 14};
    int rr_i[5] = '{0, 1, 2, 3, 0};
    int lk_c[4] = '{2, 4, 6, 9};
    int lk_i[4] = '{0, 0, 0, 1};
    int n_ack1;
    logic [3:0] prev_ack;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        model_reset();

        tbl[0] = '{4'b0100, 4'b0, 16'h0A00, 4'b0000,
                   4'b0000, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[1] = '{4'b0100, 4'b0, 16'h0A00, 4'b0100,
                   4'b0000, 1'b1, 4'hA, 1'b1, 1'b0};
        tbl[2] = '{4'b0100, 4'b0, 16'h0A00, 4'b0100,
                   4'b0100, 1'b0, 4'hA, 1'b1, 1'b0};
        tbl[3] = '{4'b0000, 4'b0, 16'h0000, 4'b0000,
                   4'b0000, 1'b0, 4'hA, 1'b0, 1'b0};

        // single write via table
        do_reset();
        for (int r = 0; r < 4; r++) begin
            bus.req   = tbl[r].req;
            bus.lock  = tbl[r].lock;
            bus.wdata = tbl[r].wdata;
            #1;
            chk($sformatf("t%0d_gnt", r), 32'(bus.gnt), 32'(tbl[r].gnt));
            chk($sformatf("t%0d_ack", r), 32'(bus.ack), 32'(tbl[r].ack));
            chk($sformatf("t%0d_upd", r), 32'(bus.update),
                32'(tbl[r].upd));
            chk($sformatf("t%0d_nv", r), 32'(bus.new_value),
                32'(tbl[r].nv));
            chk($sformatf("t%0d_busy", r), 32'(bus.busy),
                32'(tbl[r].busy));
            chk($sformatf("t%0d_err", r), 32'(bus.err), 32'(tbl[r].err));
            check_model();
            step();
        end

        // round robin with all requesting
        do_reset();
        got_c.delete();
        got_i.delete();
        bus.req   = 4'b1111;
        bus.wdata = 16'h4321;
        for (int c = 0; c <= 14; c++) begin
            #1;
            check_model();
            if (bus.ack != 0) begin
                got_c.push_back(c);
                got_i.push_back(idx_of(bus.ack));
            end
            step();
        end
        chk("rr_count", 32'(got_c.size()), 5);
        for (int k = 0; k < 5 && k < got_c.size(); k++) begin
            chk($sformatf("rr_cyc%0d", k), 32'(got_c[k]), 32'(rr_c[k]));
            chk($sformatf("rr_idx%0d", k), 32'(got_i[k]), 32'(rr_i[k]));
        end

        // lock bound
        do_reset();
        got_c.delete();
        got_i.delete();
        bus.req   = 4'b0011;
        bus.lock  = 4'b0001;
        bus.wdata = 16'h0021;
        for (int c = 0; c <= 10; c++) begin
            #1;
            check_model();
            if (bus.ack != 0) begin
                got_c.push_back(c);
                got_i.push_back(idx_of(bus.ack));
            end
            step();
        end
        chk("lk_count", 32'(got_c.size()), 4);
        for (int k = 0; k < 4 && k < got_c.size(); k++) begin
            chk($sformatf("lk_cyc%0d", k), 32'(got_c[k]), 32'(lk_c[k]));
            chk($sformatf("lk_idx%0d", k), 32'(got_i[k]), 32'(lk_i[k]));
        end

        // read-back error then clean write
        do_reset();
        force_en  = 1'b1;
        force_val = 4'h5;
        bus.req   = 4'b0001;
        bus.wdata = 16'h0006;
        for (int c = 0; c <= 3; c++) begin
            if (c == 3) bus.req = '0;
            #1;
            check_model();
            chk($sformatf("err_c%0d", c), 32'(bus.err), 32'(c == 2));
            step();
        end
        force_en  = 1'b0;
        bus.req   = 4'b0001;
        bus.wdata = 16'h0007;
        for (int c = 0; c <= 3; c++) begin
            if (c == 3) bus.req = '0;
            #1;
            check_model();
            if (c == 2) begin
                chk("ok_ack", 32'(bus.ack), 32'h1);
                chk("ok_err", 32'(bus.err), 0);
            end
            step();
        end

        // reset during WRITE
        do_reset();
        bus.req   = 4'b0001;
        bus.wdata = 16'h0003;
        #1;
        check_model();
        step();
        #1;
        chk("mid_upd_pre", 32'(bus.update), 1);
        rst = 1'b1;
        #1;
        model_reset();
        chk("mid_upd", 32'(bus.update), 0);
        chk("mid_gnt", 32'(bus.gnt), 0);
        chk("mid_busy", 32'(bus.busy), 0);
        bus.req   = 4'b1000;
        bus.wdata = 16'h9000;
        step();
        rst = 1'b0;
        #1;
        check_model();
        step();
        #1;
        chk("mid_gnt3", 32'(bus.gnt), 32'h8);
        chk("mid_nv3", 32'(bus.new_value), 32'h9);
        check_model();
        step();
        bus.req = '0;
        step();

        // early drop of req during WRITE
        do_reset();
        bus.req   = 4'b0010;
        bus.wdata = 16'h0050;
        #1;
        check_model();
        step();
        bus.req = '0;
        #1;
        chk("drop_upd", 32'(bus.update), 1);
        check_model();
        step();
        #1;
        chk("drop_ack", 32'(bus.ack), 32'h2);
        check_model();
        step();
        #1;
        chk("drop_busy", 32'(bus.busy), 0);
        n_ack1 = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            check_model();
            if (bus.ack[1] || bus.update) n_ack1++;
            step();
        end
        chk("drop_no_rewrite", 32'(n_ack1), 0);

        // random traffic against the model
        do_reset();
        prev_ack = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (prev_ack[i]) begin
                    if ($urandom_range(1, 0) == 0) bus.req[i] = 1'b0;
                end else if (!bus.req[i]) begin
                    if ($urandom_range(2, 0) == 0) begin
                        bus.req[i] = 1'b1;
                        bus.wdata[i*W +: W] = W'($urandom);
                    end
                end else if ($urandom_range(39, 0) == 0) begin
                    bus.req[i] = 1'b0;
                end
                bus.lock[i] = $urandom_range(1, 0) == 1;
            end
            force_en  = $urandom_range(9, 0) == 0;
            force_val = W'($urandom);
            prev_ack  = (m_phase == 2) ? 4'(1 << m_owner) : 4'b0;
            #1;
            check_model();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
